// File: rtl/keypad_scanner_if.sv
// Key-code handshake from the scanner FIFO head to its consumer.
// master drives code/valid and samples ready; slave is the consumer side.
interface keypad_scanner_if #(
    parameter int CODE_W = 4
) ();
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with per-press debounce and a {row,col} code FIFO; `KEYPAD_REPEAT_EN adds auto-repeat.
// Push on the DEBOUNCE-th agreeing sample, code visible next cycle; a full FIFO (no same-cycle pop) drops the code and pulses overflow.
module keypad_scanner_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         full, wr_fire, rd_fire;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_vld  = (wptr != rptr);
    assign rd_fire = rd_vld && rd_rdy;
    // A pop frees the head slot in the same edge, so a full queue still accepts.
    assign wr_rdy  = !full || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_dat  = rd_vld ? mem[rptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_fire) wptr <= wptr + 1'b1;
            if (rd_fire) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wptr[AW-1:0]] <= wr_dat;
    end
endmodule

module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE     = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] key_row,
    output logic [COLS-1:0] key_col,
    keypad_scanner_if.master kif,
    output logic            key_held,
    output logic            overflow
);
    localparam int DVW = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(DEBOUNCE + 1);

    if (SCAN_DIV < 2 || DEBOUNCE < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED} state_t;

    state_t          state, state_nxt;
    logic [DVW-1:0]  div;
    logic [CW-1:0]   col, col_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt, rcnt, rcnt_nxt;
    logic [ROWS-1:0] pat, pat_nxt;
    logic [RW-1:0]   row_idx;
    logic            sample, push, push_all, fifo_wr_rdy;

    assign sample   = (div == DVW'(SCAN_DIV - 1));
    assign key_col  = ~(COLS'(1) << col);
    assign key_held = (state == S_PRESSED);

    always_ff @(posedge clk) begin
        if (reset || sample) div <= '0;
        else                 div <= div + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SCAN;
            col   <= '0;
            dcnt  <= '0;
            rcnt  <= '0;
            pat   <= '1;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            dcnt  <= dcnt_nxt;
            rcnt  <= rcnt_nxt;
            pat   <= pat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        dcnt_nxt  = dcnt;
        rcnt_nxt  = rcnt;
        pat_nxt   = pat;
        push      = 1'b0;
        if (sample) begin
            case (state)
                S_SCAN: begin
                    if (key_row != '1) begin
                        pat_nxt  = key_row;
                        dcnt_nxt = DW'(1);
                        if (DEBOUNCE == 1) begin
                            push      = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = S_PRESSED;
                        end else begin
                            state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (key_row == pat) begin
                        dcnt_nxt = dcnt + 1'b1;
                        if (dcnt_nxt == DW'(DEBOUNCE)) begin
                            push      = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = S_PRESSED;
                        end
                    end else begin
                        state_nxt = S_SCAN;
                    end
                end
                S_PRESSED: begin
                    // Only an all-released run ends the press; pattern changes are ignored.
                    if (key_row == '1) begin
                        rcnt_nxt = rcnt + 1'b1;
                        if (rcnt_nxt == DW'(DEBOUNCE)) state_nxt = S_SCAN;
                    end else begin
                        rcnt_nxt = '0;
                    end
                end
                default: state_nxt = S_SCAN;
            endcase
            if (state_nxt == S_SCAN) col_nxt = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
        end
    end

    always_comb begin
        row_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!pat_nxt[i]) row_idx = RW'(i);
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0] hcnt, hcnt_nxt;
    logic          rep_phase, rep_phase_nxt, rep_push;

    // rep_phase selects the initial delay or the steady repeat interval.
    always_comb begin
        hcnt_nxt      = hcnt;
        rep_phase_nxt = rep_phase;
        rep_push      = 1'b0;
        if (state != S_PRESSED) begin
            hcnt_nxt      = '0;
            rep_phase_nxt = 1'b0;
        end else if (sample) begin
            if (key_row == '1) begin
                hcnt_nxt      = '0;
                rep_phase_nxt = 1'b0;
            end else begin
                hcnt_nxt = hcnt + 1'b1;
                if (hcnt_nxt == (rep_phase ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY))) begin
                    rep_push      = 1'b1;
                    hcnt_nxt      = '0;
                    rep_phase_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt      <= '0;
            rep_phase <= 1'b0;
        end else begin
            hcnt      <= hcnt_nxt;
            rep_phase <= rep_phase_nxt;
        end
    end

    assign push_all = push || rep_push;
`else
    assign push_all = push;
`endif

    keypad_scanner_fifo #(
        .W     (RW + CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push_all),
        .wr_dat ({row_idx, col}),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (kif.key_valid),
        .rd_rdy (kif.key_ready),
        .rd_dat (kif.key_code)
    );

    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= push_all && !fifo_wr_rdy;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed timing checks, random presses and a code scoreboard.
module tb_keypad_scanner;
    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_row, key_col;
    logic       key_held, overflow;
    logic [3:0] pressed [4];
    int         cyc = 0;
    int         n_checks = 0, n_fail = 0;
    int         pops = 0, ovf_cycles = 0;
    logic [3:0] exp_q [$];

    keypad_scanner_if #(.CODE_W(4)) kif ();

    keypad_scanner dut (
        .clk      (clk),
        .reset    (reset),
        .key_row  (key_row),
        .key_col  (key_col),
        .kif      (kif),
        .key_held (key_held),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // Physical keypad: a closed switch pulls its row low while its column is strobed.
    always_comb begin
        key_row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic       prev_stall = 1'b0;
    logic [3:0] prev_code  = '0;
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && kif.key_valid) check_eq("code_stable", kif.key_code, prev_code);
            if (kif.key_valid && kif.key_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_code: got %0d, expected no code (cycle %0d)", kif.key_code, cyc);
                end else begin
                    check_eq("code_order", kif.key_code, exp_q.pop_front());
                end
            end
            if (overflow) ovf_cycles++;
            prev_stall = kif.key_valid && !kif.key_ready;
            prev_code  = kif.key_code;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_eq("rst_key_col", key_col, 4'b1110);
        check_eq("rst_key_valid", kif.key_valid, 0);
        check_eq("rst_key_code", kif.key_code, 0);
        check_eq("rst_key_held", key_held, 0);
        check_eq("rst_overflow", overflow, 0);
        reset = 1'b0;
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic hold(input int n, input bit rnd_rdy);
        repeat (n) begin
            @(negedge clk);
            if (rnd_rdy) kif.key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press_keys(input int r1, input int r2, input int c, input bit expect_code, input bit rnd_rdy);
        int rmin;
        rmin = (r1 < r2) ? r1 : r2;
        pressed[r1][c] = 1'b1;
        pressed[r2][c] = 1'b1;
        if (expect_code) exp_q.push_back(4'(rmin * 4 + c));
        hold(200, rnd_rdy);
        pressed[r1][c] = 1'b0;
        pressed[r2][c] = 1'b0;
        hold(100, rnd_rdy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, o0, exp_n;
        bit saw_valid;
        kif.key_ready = 1'b1;
        for (int r = 0; r < 4; r++) pressed[r] = '0;

        // Single press: row 2 in column 1 from reset release
        do_reset();
        p0 = pops;
        pressed[2][1] = 1'b1;
        exp_q.push_back(4'b1001);
        at_cyc(15); check_eq("col0_driven", key_col, 4'b1110);
        at_cyc(16); check_eq("col1_driven", key_col, 4'b1101);
        at_cyc(79);
        check_eq("valid_before_push", kif.key_valid, 0);
        check_eq("held_before_push", key_held, 0);
        at_cyc(80);
        check_eq("valid_after_push", kif.key_valid, 1);
        check_eq("first_code", kif.key_code, 4'b1001);
        check_eq("held_after_push", key_held, 1);
        check_eq("col_frozen", key_col, 4'b1101);
        at_cyc(400); pressed[2][1] = 1'b0;
        at_cyc(463); check_eq("held_until_release", key_held, 1);
        at_cyc(464); check_eq("held_falls", key_held, 0);
        at_cyc(520); check_eq("single_code_count", pops - p0, 1);

        // Bounce during debounce
        do_reset();
        p0 = pops;
        pressed[0][1] = 1'b1;
        at_cyc(40); pressed[0][1] = 1'b0;
        at_cyc(47); check_eq("bounce_col_before", key_col, 4'b1101);
        at_cyc(48); check_eq("bounce_col_next", key_col, 4'b1011);
        at_cyc(50); pressed[0][1] = 1'b1;
        at_cyc(60); pressed[0][1] = 1'b0;
        saw_valid = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            if (kif.key_valid) saw_valid = 1'b1;
        end
        check_eq("bounce_no_valid", saw_valid, 0);
        check_eq("bounce_no_code", pops - p0, 0);

        // Multi-row in one column, then random presses with random backpressure
        press_keys(1, 3, 3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            int c, r1, r2;
            c  = $urandom_range(0, 3);
            r1 = $urandom_range(0, 3);
            r2 = ($urandom_range(0, 1) != 0) ? r1 : int'($urandom_range(0, 3));
            press_keys(r1, r2, c, 1'b1, 1'b1);
        end
        kif.key_ready = 1'b1;
        hold(20, 1'b0);
        check_eq("random_drained", exp_q.size(), 0);

        // Backpressure and overflow: fifth press is dropped
        kif.key_ready = 1'b0;
        o0 = ovf_cycles;
        press_keys(0, 0, 0, 1'b1, 1'b0);
        press_keys(1, 1, 1, 1'b1, 1'b0);
        press_keys(2, 2, 2, 1'b1, 1'b0);
        press_keys(3, 3, 3, 1'b1, 1'b0);
        press_keys(0, 0, 2, 1'b0, 1'b0);
        check_eq("overflow_pulses", ovf_cycles - o0, 1);
        kif.key_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("drain_valid", kif.key_valid, 1);
            @(negedge clk);
        end
        check_eq("drain_done_valid", kif.key_valid, 0);
        check_eq("drain_queue", exp_q.size(), 0);

        // Reset during debounce with a code queued
        kif.key_ready = 1'b0;
        do_reset();
        pressed[1][0] = 1'b1;
        exp_q.push_back(4'b0100);
        at_cyc(100); pressed[1][0] = 1'b0;
        at_cyc(170); pressed[2][1] = 1'b1;
        at_cyc(180); check_eq("queued_before_reset", kif.key_valid, 1);
        do_reset();
        exp_q.push_back(4'b1001);
        kif.key_ready = 1'b1;
        at_cyc(79); check_eq("redetect_not_yet", kif.key_valid, 0);
        at_cyc(80);
        check_eq("redetect_valid", kif.key_valid, 1);
        check_eq("redetect_code", kif.key_code, 4'b1001);
        at_cyc(150);
        pressed[2][1] = 1'b0;
        check_eq("redetect_drained", exp_q.size(), 0);

        // Held key for 60 samples after acceptance
        do_reset();
        p0 = pops;
        exp_n = 1;
`ifdef KEYPAD_REPEAT_EN
        exp_n = 5;
`endif
        pressed[3][0] = 1'b1;
        for (int k = 0; k < exp_n; k++) exp_q.push_back(4'b1100);
        at_cyc(1030); pressed[3][0] = 1'b0;
        at_cyc(1150);
        check_eq("repeat_code_count", pops - p0, exp_n);
        check_eq("repeat_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
